// File: rtl/gaussian_pkg.sv
// rtl/gaussian_pkg.sv - shared geometry, FSM states and window packing for the gaussian pipeline
package gaussian_pkg;

   localparam int BITS     = 8;
   localparam int WIDTH    = 7;
   localparam int WIN_BITS = WIDTH * WIDTH * BITS;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   // LSB position of A[i][j] inside a packed window; A[0][0] lands in the top byte
   function automatic int win_lsb(input int i, input int j, input int w, input int b);
      return (w * w - 1 - (w * i + j)) * b;
   endfunction

endpackage

// File: rtl/gaussian_line_buffer.sv
// rtl/gaussian_line_buffer.sv - one-line delay: read the previous line's pixel, write the current one
module gaussian_line_buffer #(
   parameter int DEPTH = 64,
   parameter int BITS  = 8,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic            clk,
   input  logic            en,
   input  logic [AW-1:0]   addr,
   input  logic [BITS-1:0] din,
   output logic [BITS-1:0] dout
);

   logic [BITS-1:0] mem [DEPTH];

   // Read-before-write at the same column gives the pixel exactly one line back
   assign dout = mem[addr];

   always_ff @(posedge clk) begin
      if (en) begin
         mem[addr] <= din;
      end
   end

endmodule

// File: rtl/gaussian_window_gen.sv
// rtl/gaussian_window_gen.sv - raster pixel stream to 7x7 sliding windows (valid positions only)
module gaussian_window_gen #(
   parameter int BITS  = gaussian_pkg::BITS,
   parameter int WIDTH = gaussian_pkg::WIDTH,
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [BITS-1:0]             pix_in,
   input  logic                        pix_valid,
   input  logic                        pix_sof,
   output logic                        pix_ready,
   output logic [WIDTH*WIDTH*BITS-1:0] window_pixels,
   output logic                        window_valid,
   input  logic                        window_ready,
   output logic                        frame_done
);

   import gaussian_pkg::*;

   localparam int CW  = $clog2(IMG_W);
   localparam int RW  = $clog2(IMG_H);
   localparam int NLB = WIDTH - 1;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_EDGE = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_EDGE = RW'(WIDTH - 1);

   state_t state, state_next;

   logic [CW-1:0] col, cur_col;
   logic [RW-1:0] row, cur_row;
   logic          accept, take, last_pix, load;

   logic [BITS-1:0] lb_in   [NLB];
   logic [BITS-1:0] lb_out  [NLB];
   logic [BITS-1:0] col_vec [WIDTH];
   logic [BITS-1:0] win      [WIDTH][WIDTH];
   logic [BITS-1:0] win_next [WIDTH][WIDTH];
   logic [WIDTH*WIDTH*BITS-1:0] win_packed;

   // IDLE always accepts so stray pixels drain; RUN stalls only on a held window
   assign pix_ready = (state == IDLE) || !window_valid || window_ready;
   assign accept    = pix_valid && pix_ready;
   assign take      = accept && ((state == RUN) || pix_sof);

   assign cur_col  = pix_sof ? '0 : col;
   assign cur_row  = pix_sof ? '0 : row;
   assign last_pix = take && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
   assign load     = take && (cur_row >= ROW_EDGE) && (cur_col >= COL_EDGE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (take)     state_next = RUN;
         RUN:     if (last_pix) state_next = IDLE;
         default:               state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row           <= '0;
         col           <= '0;
         frame_done    <= 1'b0;
         window_valid  <= 1'b0;
         window_pixels <= '0;
      end else begin
         frame_done <= last_pix;
         if (take) begin
            if (cur_col == COL_LAST) begin
               col <= '0;
               row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
               col <= cur_col + 1'b1;
               row <= cur_row;
            end
         end
         if (load) begin
            window_valid  <= 1'b1;
            window_pixels <= win_packed;
         end else if (window_ready) begin
            window_valid <= 1'b0;
         end
      end
   end

   assign lb_in[0] = pix_in;

   genvar g;
   generate
      for (g = 0; g < NLB; g++) begin : g_lb
         if (g > 0) begin : g_chain
            assign lb_in[g] = lb_out[g-1];
         end
         gaussian_line_buffer #(
            .DEPTH (IMG_W),
            .BITS  (BITS)
         ) u_lb (
            .clk  (clk),
            .en   (take),
            .addr (cur_col),
            .din  (lb_in[g]),
            .dout (lb_out[g])
         );
      end
   endgenerate

   // Newest column: bottom row is the live pixel, upper rows come from older line buffers
   always_comb begin
      col_vec[WIDTH-1] = pix_in;
      for (int k = 0; k < NLB; k++) begin
         col_vec[WIDTH-2-k] = lb_out[k];
      end
   end

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH - 1; j++) begin
            win_next[i][j] = win[i][j+1];
         end
         win_next[i][WIDTH-1] = col_vec[i];
      end
   end

   always_comb begin
      win_packed = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            win_packed[win_lsb(i, j, WIDTH, BITS) +: BITS] = win_next[i][j];
         end
      end
   end

   // Stale columns after a restart are never exposed: a window needs WIDTH fresh shifts
   always_ff @(posedge clk) begin
      if (take) begin
         win <= win_next;
      end
   end

endmodule

// File: doc/gaussian_window_gen.md
GAUSSIAN_WINDOW_GEN -- requirements
Module: gaussian_window_gen

Interface
REQ-001 Parameter BITS, default 8, bits per pixel.
REQ-002 Parameter WIDTH, default 7, window edge in pixels.
REQ-003 Parameter IMG_W, default 64, pixels per image line; legal range WIDTH..1024.
REQ-004 Parameter IMG_H, default 64, lines per frame; legal range WIDTH..1024.
REQ-005 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 Port pix_in, input, BITS, raster-order pixel, left to right and top to bottom.
REQ-008 Port pix_valid, input, 1, pix_in is valid.
REQ-009 Port pix_sof, input, 1, qualified by pix_valid, marks pixel (0,0) of a frame.
REQ-010 Port pix_ready, output, 1, block accepts pix_in this cycle.
REQ-011 Port window_pixels, output, WIDTH*WIDTH*BITS (392), 7x7 window for the gaussian core.
REQ-012 Port window_valid, output, 1, window_pixels holds a complete window.
REQ-013 Port window_ready, input, 1, downstream consumes the window.
REQ-014 Port frame_done, output, 1, one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-015 Transfers SHALL occur on pix_valid && pix_ready; windows SHALL transfer on window_valid && window_ready.
REQ-016 pix_ready SHALL equal (!window_valid || window_ready) && state != IDLE, or state == IDLE; it SHALL be combinational, with no combinational path from pix_valid.
REQ-017 FSM states: IDLE (pixels without pix_sof are dropped while pix_ready=1); RUN, entered on an accepted pix_sof pixel; the last pixel (IMG_H-1, IMG_W-1) returns the FSM to IDLE and pulses frame_done.
REQ-018 In RUN, an accepted pix_sof pixel SHALL restart the frame: row=0, col=0 for that pixel; partial line-buffer contents are ignored.
REQ-019 Column counter SHALL wrap from IMG_W-1 to 0 and increment row; row SHALL wrap to 0 at frame end.
REQ-020 Six line buffers SHALL hold the previous six lines; a 7x7 shift register SHALL hold the current window columns.
REQ-021 Accepting the pixel at (r,c) with r>=6 and c>=6 SHALL set window_valid on the next cycle; the window covers rows r-6..r and columns c-6..c.
REQ-022 There are no border windows; each frame SHALL produce exactly (IMG_W-6)*(IMG_H-6) windows (3364 at defaults).
REQ-023 Packing: A[i][j] (i = row offset from the top, j = column offset from the left) SHALL occupy bits [391-8*(7i+j) -: 8], so A[0][0] is the MSB byte and A[6][6] the LSB byte.
REQ-024 window_pixels and window_valid SHALL hold stable while window_valid && !window_ready.
REQ-025 window_valid SHALL clear after a transfer unless a new window is loaded in the same cycle.
REQ-026 Latency: one cycle from accepting the pixel to window_valid; sustained throughput is one pixel per cycle when window_ready=1.

Reset
REQ-027 Asserting rst_n low SHALL immediately force window_valid=0, frame_done=0, state=IDLE, row=0, col=0, and window_pixels=0.
REQ-028 Line-buffer storage SHALL NOT require reset; its contents are never used before being rewritten in the current frame.
REQ-029 Reset mid-frame SHALL discard the frame; output SHALL resume only after the next pix_sof.

Structure
REQ-030 Shared package gaussian_pkg SHALL hold BITS, WIDTH, WIN_BITS=WIDTH*WIDTH*BITS, and the window-packing index function used by both this block and gaussian_core.
REQ-031 One sub-module, gaussian_line_buffer: a single-port-read/single-port-write delay line of depth IMG_W and width BITS, instantiated six times (or once at width 6*BITS).

Verification
REQ-032 IMG_W=IMG_H=8, pixel=(8r+c), no stall -> exactly 4 windows; first window A[0][0]=0, A[6][6]=54, appearing the cycle after pixel (6,6) is accepted; last window A[6][6]=63.
REQ-033 Same frame with window_ready low for 5 cycles while window_valid=1 -> pix_ready=0, window_pixels stable, no window lost or duplicated.
REQ-034 Constant image of 100 at defaults -> 3364 windows, every byte 0x64, one frame_done pulse.
REQ-035 rst_n asserted after pixel (3,2), then a new frame -> no window from the aborted frame; the new frame's first window matches REQ-032.
REQ-036 pix_sof reasserted at pixel (7,3) of a frame -> the frame restarts; window count and contents match a clean frame.
REQ-037 Pixels without pix_sof in IDLE -> dropped, no window_valid, pix_ready=1.
